// File: rtl/sha2_block_sequencer_pkg.sv
// Shared sizes and the state encoding for the SHA-256 block sequencer.
package sha2_pkg;

   localparam int WORD_SIZE    = 32;
   localparam int ROUNDS       = 64;
   localparam int SCHED_WORDS  = 16;
   localparam int ROUND_IDX_W  = $clog2(ROUNDS);
   localparam int SCHED_ADDR_W = $clog2(SCHED_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PREP,
      ROUND,
      UPDATE,
      DONE
   } seq_state_t;

endpackage

// File: rtl/sha2_block_sequencer_if.sv
// Block/word/digest handshakes plus the datapath control bus of the sequencer.
interface sha2_block_sequencer_if;
   import sha2_pkg::*;

   logic                    blk_valid;
   logic                    blk_first;
   logic                    blk_last;
   logic                    blk_ready;
   logic [WORD_SIZE-1:0]    word_in;
   logic                    word_valid;
   logic                    word_ready;
   logic                    sched_we;
   logic [SCHED_ADDR_W-1:0] sched_addr;
   logic [WORD_SIZE-1:0]    sched_data;
   logic                    hash_init;
   logic                    wv_load;
   logic                    round_en;
   logic [ROUND_IDX_W-1:0]  round_idx;
   logic                    hash_update;
   logic                    busy;
   logic                    digest_valid;
   logic                    digest_ready;

   modport master (
      output blk_valid, blk_first, blk_last, word_in, word_valid, digest_ready,
      input  blk_ready, word_ready, sched_we, sched_addr, sched_data, hash_init,
             wv_load, round_en, round_idx, hash_update, busy, digest_valid
   );

   modport slave (
      input  blk_valid, blk_first, blk_last, word_in, word_valid, digest_ready,
      output blk_ready, word_ready, sched_we, sched_addr, sched_data, hash_init,
             wv_load, round_en, round_idx, hash_update, busy, digest_valid
   );

endinterface

// File: rtl/sha2_block_sequencer_step_counter.sv
// Up-counter with terminal-count compare; wraps to zero when stepped at TERM.
module sha2_step_counter #(
   parameter int WIDTH = 4,
   parameter int TERM  = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

   assign tc = (cnt == TERM_V);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/sha2_block_sequencer.sv
// Sequences one SHA-256 compression per 512-bit block: word load, 64 rounds,
// hash update and digest handshake.
//
// state  | meaning
// IDLE   | waiting for a block descriptor
// LOAD   | accepting the 16 message words into the schedule
// PREP   | loading working variables a..h from H
// ROUND  | one compression round per cycle, idx 0..63
// UPDATE | H += working variables
// DONE   | digest held until the consumer takes it
module sha2_block_sequencer
   import sha2_pkg::*;
(
   input logic                   clock,
   input logic                   reset,
   input logic                   clear,
   sha2_block_sequencer_if.slave bus
);

   seq_state_t              state;
   logic                    last_q;
   logic [SCHED_ADDR_W-1:0] word_cnt;
   logic                    word_tc;
   logic [ROUND_IDX_W-1:0]  round_cnt;
   logic                    round_tc;

   assign bus.blk_ready  = (state == IDLE);
   assign bus.word_ready = (state == LOAD);
   assign bus.round_idx  = round_cnt;

   sha2_step_counter #(.WIDTH(SCHED_ADDR_W), .TERM(SCHED_WORDS - 1)) u_word_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (clear || (state == IDLE)),
      .en    ((state == LOAD) && bus.word_valid),
      .cnt   (word_cnt),
      .tc    (word_tc)
   );

   sha2_step_counter #(.WIDTH(ROUND_IDX_W), .TERM(ROUNDS - 1)) u_round_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (clear || (state != ROUND)),
      .en    (state == ROUND),
      .cnt   (round_cnt),
      .tc    (round_tc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         last_q           <= 1'b0;
         bus.sched_we     <= 1'b0;
         bus.sched_addr   <= '0;
         bus.sched_data   <= '0;
         bus.hash_init    <= 1'b0;
         bus.wv_load      <= 1'b0;
         bus.round_en     <= 1'b0;
         bus.hash_update  <= 1'b0;
         bus.busy         <= 1'b0;
         bus.digest_valid <= 1'b0;
      end else begin
         bus.sched_we    <= 1'b0;
         bus.hash_init   <= 1'b0;
         bus.wv_load     <= 1'b0;
         bus.hash_update <= 1'b0;
         if (clear) begin
            state            <= IDLE;
            bus.round_en     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.digest_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.blk_valid) begin
                     last_q        <= bus.blk_last;
                     bus.hash_init <= bus.blk_first;
                     bus.busy      <= 1'b1;
                     state         <= LOAD;
                  end
               end
               LOAD: begin
                  if (bus.word_valid) begin
                     bus.sched_we   <= 1'b1;
                     bus.sched_addr <= word_cnt;
                     bus.sched_data <= bus.word_in;
                     // slot 15 write lands in the PREP cycle alongside wv_load
                     if (word_tc) begin
                        bus.wv_load <= 1'b1;
                        state       <= PREP;
                     end
                  end
               end
               PREP: begin
                  bus.round_en <= 1'b1;
                  state        <= ROUND;
               end
               ROUND: begin
                  if (round_tc) begin
                     bus.round_en    <= 1'b0;
                     bus.hash_update <= 1'b1;
                     state           <= UPDATE;
                  end
               end
               UPDATE: begin
                  if (last_q) begin
                     bus.digest_valid <= 1'b1;
                     state            <= DONE;
                  end else begin
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
               DONE: begin
                  if (bus.digest_ready) begin
                     bus.digest_valid <= 1'b0;
                     bus.busy         <= 1'b0;
                     state            <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha2_block_sequencer.sv
// Directed bench for sha2_block_sequencer: table of block scenarios plus
// hand-written clear, backpressure and async-reset sequences.
module tb_sha2_block_sequencer;
   import sha2_pkg::*;

   logic clock;
   logic reset;
   logic clear;

   sha2_block_sequencer_if bus();

   sha2_block_sequencer dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [18:0] RST_VEC = 19'h40000;
   logic [18:0] outs_vec;
   assign outs_vec = {bus.blk_ready, bus.word_ready, bus.sched_we, bus.sched_addr,
                      bus.hash_init, bus.wv_load, bus.round_en, bus.round_idx,
                      bus.hash_update, bus.busy, bus.digest_valid};

   typedef struct {
      logic f;
      logic l;
      int   ga;
      int   gb;
      int   gl;
      bit   pat;
      int   e_hinit;
      int   e_load;
      int   e_upd;
   } vec_t;

   typedef struct {
      int hinit;
      int we;
      int wv;
      int ren;
      int seq_err;
      int load_cyc;
      int upd;
      int cleared;
   } res_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] word_val(input bit pat, input int i);
      if (pat) return (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
      return {8'(i), 8'hC3, 8'(15 - i), 8'h5A};
   endfunction

   // Offers one block and runs it until hash_update (or until clear at stop_idx).
   task automatic run_block(input logic f, input logic l, input int ga, input int gb,
                            input int gl, input bit pat, input int stop_idx, output res_t r);
      int  wi;
      int  gap_left;
      int  exp_idx;
      int  exp_addr;
      bit  pres;
      r = '{0, 0, 0, 0, 0, 0, 0, 0};
      wi = 0; gap_left = 0; exp_idx = 0; exp_addr = 0;
      bus.blk_valid = 1'b1; bus.blk_first = f; bus.blk_last = l;
      for (int k = 0; k < 50 && !bus.blk_ready; k++) tick();
      tick();
      bus.blk_valid = 1'b0; bus.blk_first = 1'b0; bus.blk_last = 1'b0;
      for (int cyc = 1; cyc < 400; cyc++) begin
         if (bus.hash_init) r.hinit++;
         if (bus.word_ready) r.load_cyc++;
         if (bus.sched_we) begin
            r.we++;
            if (int'(bus.sched_addr) != exp_addr || bus.sched_data != word_val(pat, exp_addr))
               r.seq_err++;
            exp_addr++;
         end
         if (bus.wv_load) begin
            r.wv++;
            if (!(bus.sched_we && bus.sched_addr == 4'd15)) r.seq_err++;
         end
         if (bus.round_en) begin
            r.ren++;
            if (int'(bus.round_idx) != exp_idx) r.seq_err++;
            exp_idx++;
         end
         if (bus.round_en && int'(bus.round_idx) == stop_idx) begin
            bus.word_valid = 1'b0;
            clear = 1'b1;
            tick();
            clear = 1'b0;
            r.cleared = 1;
            return;
         end
         if (bus.hash_update) begin
            bus.word_valid = 1'b0;
            r.upd = cyc;
            return;
         end
         pres = 1'b0;
         if (gap_left > 0) gap_left--;
         else if (wi < 16 && bus.word_ready) pres = 1'b1;
         bus.word_valid = pres;
         bus.word_in    = pres ? word_val(pat, wi) : 32'hDEADBEEF;
         tick();
         if (pres) begin
            if (wi == ga || wi == gb) gap_left = gl;
            wi++;
         end
      end
      bus.word_valid = 1'b0;
   endtask

   task automatic chk_block(input string tag, input res_t r, input int e_hinit,
                            input int e_load, input int e_upd);
      chk({tag, ".hash_init_cnt"}, 64'(r.hinit), 64'(e_hinit));
      chk({tag, ".sched_we_cnt"},  64'(r.we), 64'd16);
      chk({tag, ".wv_load_cnt"},   64'(r.wv), 64'd1);
      chk({tag, ".round_en_cnt"},  64'(r.ren), 64'd64);
      chk({tag, ".sequence_err"},  64'(r.seq_err), 64'd0);
      chk({tag, ".load_cycles"},   64'(r.load_cyc), 64'(e_load));
      chk({tag, ".update_cycle"},  64'(r.upd), 64'(e_upd));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int   bp_err;
      reset = 1'b1; clear = 1'b0;
      bus.blk_valid = 1'b0; bus.blk_first = 1'b0; bus.blk_last = 1'b0;
      bus.word_in = '0; bus.word_valid = 1'b0; bus.digest_ready = 1'b0;

      vecs[0] = '{1'b1, 1'b1, -1, -1, 0, 1'b1, 1, 16, 82};
      vecs[1] = '{1'b1, 1'b0, -1, -1, 0, 1'b0, 1, 16, 82};
      vecs[2] = '{1'b0, 1'b1,  4, 11, 3, 1'b0, 0, 22, 88};
      vecs[3] = '{1'b0, 1'b0,  0,  7, 1, 1'b0, 0, 18, 84};

      #1 reset = 1'b0;
      #2;
      chk("reset_outputs", 64'(outs_vec), 64'(RST_VEC));
      chk("reset_sched_data", 64'(bus.sched_data), 64'd0);
      tick(); tick();
      #2 reset = 1'b1;
      tick();

      bus.blk_valid = 1'b1; bus.blk_first = 1'b1; clear = 1'b1;
      tick();
      chk("clear_beats_blk", 64'({bus.blk_ready, bus.word_ready, bus.busy, bus.hash_init}), 64'(4'b1000));
      clear = 1'b0; bus.blk_valid = 1'b0; bus.blk_first = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_block(vecs[i].f, vecs[i].l, vecs[i].ga, vecs[i].gb, vecs[i].gl, vecs[i].pat, -1, r);
         chk_block($sformatf("vec%0d", i), r, vecs[i].e_hinit, vecs[i].e_load, vecs[i].e_upd);
         tick();
         chk($sformatf("vec%0d.post_update", i),
             64'({bus.hash_update, bus.digest_valid, bus.blk_ready, bus.busy}),
             64'({1'b0, vecs[i].l, !vecs[i].l, vecs[i].l}));
         if (vecs[i].l) begin
            bus.digest_ready = 1'b1;
            tick();
            chk($sformatf("vec%0d.digest_taken", i),
                64'({bus.digest_valid, bus.blk_ready, bus.busy}), 64'(3'b010));
            bus.digest_ready = 1'b0;
         end
      end

      run_block(1'b1, 1'b1, -1, -1, 0, 1'b1, -1, r);
      chk("bp.update_cycle", 64'(r.upd), 64'd82);
      bus.blk_valid = 1'b1; bus.blk_first = 1'b1; bus.blk_last = 1'b1;
      bp_err = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!(bus.digest_valid && !bus.blk_ready && bus.busy && !bus.word_ready)) bp_err++;
      end
      chk("bp.digest_held", 64'(bp_err), 64'd0);
      bus.digest_ready = 1'b1;
      tick();
      bus.digest_ready = 1'b0;
      chk("bp.back_to_idle", 64'({bus.digest_valid, bus.blk_ready, bus.word_ready}), 64'(3'b010));
      tick();
      bus.blk_valid = 1'b0;
      chk("bp.new_accept", 64'({bus.word_ready, bus.hash_init, bus.busy}), 64'(3'b111));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("bp.cleared", 64'({bus.blk_ready, bus.busy, bus.hash_init}), 64'(3'b100));

      run_block(1'b1, 1'b1, -1, -1, 0, 1'b1, 30, r);
      chk("clr30.hit", 64'(r.cleared), 64'd1);
      chk("clr30.rounds_run", 64'(r.ren), 64'd31);
      chk("clr30.after", 64'({bus.round_en, bus.busy, bus.blk_ready, bus.word_ready, bus.digest_valid}),
          64'(5'b00100));
      run_block(1'b1, 1'b1, -1, -1, 0, 1'b1, -1, r);
      chk_block("clr30.rerun", r, 1, 16, 82);
      tick();
      bus.digest_ready = 1'b1;
      tick();
      bus.digest_ready = 1'b0;
      chk("clr30.digest_taken", 64'({bus.digest_valid, bus.blk_ready}), 64'(2'b01));

      bus.blk_valid = 1'b1; bus.blk_first = 1'b1; bus.blk_last = 1'b1;
      tick();
      bus.blk_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.word_valid = 1'b1;
         bus.word_in    = word_val(1'b0, k);
         tick();
      end
      chk("arst.pre_state", 64'({bus.busy, bus.word_ready, bus.sched_we}), 64'(3'b111));
      #2 reset = 1'b0;
      #1;
      chk("arst.immediate", 64'(outs_vec), 64'(RST_VEC));
      bus.word_valid = 1'b0;
      tick();
      chk("arst.held", 64'(outs_vec), 64'(RST_VEC));
      #3 reset = 1'b1;
      tick();
      run_block(1'b1, 1'b1, -1, -1, 0, 1'b1, -1, r);
      chk_block("arst.rerun", r, 1, 16, 82);
      tick();
      chk("arst.digest", 64'({bus.digest_valid, bus.blk_ready}), 64'(2'b10));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
